// File: rtl/muldiv_pkg.sv
// muldiv_pkg
//   Shared constants for the multi-cycle multiply/divide engine:
//   FSM state encoding, operation codes, default operand width
//   and the matching iteration-counter width.
package muldiv_pkg;

   localparam int MD_WIDTH = 32;
   localparam int MD_CNT_W = $clog2(MD_WIDTH);

   localparam logic OP_MUL = 1'b0;
   localparam logic OP_DIV = 1'b1;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_FIX  = 2'd2;

endpackage

// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if
//   Handshake and operand/result bundle between control/datapath and
//   the multiply/divide engine.
//   start, op, a, b      : control/datapath -> engine
//   busy, done, z_high, z_low : engine -> control/bus mux
interface muldiv_unit_if
   import muldiv_pkg::*;
#(
   parameter int WIDTH = MD_WIDTH
) ();

   logic             start;
   logic             op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] z_high;
   logic [WIDTH-1:0] z_low;

   modport master (
      output start, op, a, b,
      input  busy, done, z_high, z_low
   );

   modport slave (
      input  start, op, a, b,
      output busy, done, z_high, z_low
   );

endinterface

// File: rtl/muldiv_unit_sign_mag.sv
// sign_mag
//   Combinational split of a two's-complement value into its sign bit
//   and unsigned magnitude.  The most negative value maps to itself,
//   which is the correct unsigned magnitude 2^(W-1).
//   value : W-bit signed input
//   sign  : value[W-1]
//   mag   : |value| as W-bit unsigned
module sign_mag #(
   parameter int W = 32
) (
   input  logic [W-1:0] value,
   output logic         sign,
   output logic [W-1:0] mag
);

   assign sign = value[W-1];
   assign mag  = sign ? (~value + W'(1)) : value;

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit
//   Multi-cycle signed multiply / divide producing the Z register pair.
//   Magnitudes are processed unsigned for WIDTH iterations, signs are
//   applied in a single fix-up cycle.
//   clock   : rising-edge clock
//   clear_n : asynchronous active-low reset
//   bus     : muldiv_unit_if slave (start/op/a/b in, busy/done/z out)
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int               WIDTH     = MD_WIDTH,
   parameter logic [WIDTH-1:0] DIV0_QUOT = '1
) (
   input  logic         clock,
   input  logic         clear_n,
   muldiv_unit_if.slave bus
);

   localparam int CW = $clog2(WIDTH);

   logic [1:0]         state_reg;
   logic [CW-1:0]      cnt_reg;
   logic               op_reg;
   logic               sa_reg;
   logic               sb_reg;
   logic               div0_reg;
   logic [WIDTH-1:0]   m_reg;      // multiplicand or divisor magnitude
   logic [2*WIDTH-1:0] pair_reg;   // {acc, multiplier} or {remainder, quotient}
   logic               done_reg;
   logic [WIDTH-1:0]   zh_reg;
   logic [WIDTH-1:0]   zl_reg;

   logic               a_sign;
   logic               b_sign;
   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;
   logic               b_zero;

   sign_mag #(.W(WIDTH)) u_sm_a (.value(bus.a), .sign(a_sign), .mag(a_mag));
   sign_mag #(.W(WIDTH)) u_sm_b (.value(bus.b), .sign(b_sign), .mag(b_mag));

   assign b_zero = (bus.b == '0);

   // Multiply step: conditional add into the high half, then shift the
   // whole pair right with the carry entering at the top.
   logic [WIDTH:0]     add_sum;
   logic [2*WIDTH-1:0] mul_next;
   assign add_sum  = {1'b0, pair_reg[2*WIDTH-1:WIDTH]} + {1'b0, m_reg};
   assign mul_next = pair_reg[0] ? {add_sum, pair_reg[WIDTH-1:1]}
                                 : {1'b0, pair_reg[2*WIDTH-1:1]};

   // Divide step: restoring.  The shifted remainder is WIDTH+1 bits so the
   // top bit of the trial difference is the borrow.
   logic [WIDTH:0]     rem_shift;
   logic [WIDTH:0]     trial;
   logic               borrow;
   logic [2*WIDTH-1:0] div_next;
   assign rem_shift = pair_reg[2*WIDTH-1:WIDTH-1];
   assign trial     = rem_shift - {1'b0, m_reg};
   assign borrow    = trial[WIDTH];
   assign div_next  = {(borrow ? rem_shift[WIDTH-1:0] : trial[WIDTH-1:0]),
                       pair_reg[WIDTH-2:0], ~borrow};

   // Sign fix-up.  Quotient follows sign(a)^sign(b); remainder follows the
   // dividend so that division truncates toward zero.
   logic               neg_res;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quot_fix;
   logic [WIDTH-1:0]   rem_fix;
   assign neg_res  = sa_reg ^ sb_reg;
   assign prod_fix = neg_res ? (~pair_reg + (2*WIDTH)'(1)) : pair_reg;
   assign quot_fix = neg_res ? (~pair_reg[WIDTH-1:0] + WIDTH'(1))
                             : pair_reg[WIDTH-1:0];
   assign rem_fix  = sa_reg ? (~pair_reg[2*WIDTH-1:WIDTH] + WIDTH'(1))
                            : pair_reg[2*WIDTH-1:WIDTH];

   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         state_reg <= ST_IDLE;
         cnt_reg   <= '0;
         op_reg    <= OP_MUL;
         sa_reg    <= 1'b0;
         sb_reg    <= 1'b0;
         div0_reg  <= 1'b0;
         m_reg     <= '0;
         pair_reg  <= '0;
         done_reg  <= 1'b0;
         zh_reg    <= '0;
         zl_reg    <= '0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (bus.start) begin
                  op_reg   <= bus.op;
                  sa_reg   <= a_sign;
                  sb_reg   <= b_sign;
                  m_reg    <= b_mag;
                  cnt_reg  <= '0;
                  div0_reg <= (bus.op == OP_DIV) && b_zero;
                  // On divide-by-zero the raw dividend is parked in the low
                  // half so FIX can return it unmodified.
                  if ((bus.op == OP_DIV) && b_zero) begin
                     pair_reg  <= {{WIDTH{1'b0}}, bus.a};
                     state_reg <= ST_FIX;
                  end else begin
                     pair_reg  <= {{WIDTH{1'b0}}, a_mag};
                     state_reg <= ST_RUN;
                  end
               end
            end
            ST_RUN: begin
               pair_reg <= (op_reg == OP_DIV) ? div_next : mul_next;
               cnt_reg  <= cnt_reg + CW'(1);
               if (cnt_reg == CW'(WIDTH - 1)) begin
                  state_reg <= ST_FIX;
               end
            end
            ST_FIX: begin
               if (div0_reg) begin
                  zh_reg <= pair_reg[WIDTH-1:0];
                  zl_reg <= DIV0_QUOT;
               end else if (op_reg == OP_DIV) begin
                  zh_reg <= rem_fix;
                  zl_reg <= quot_fix;
               end else begin
                  zh_reg <= prod_fix[2*WIDTH-1:WIDTH];
                  zl_reg <= prod_fix[WIDTH-1:0];
               end
               done_reg  <= 1'b1;
               state_reg <= ST_IDLE;
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   assign bus.busy   = (state_reg != ST_IDLE);
   assign bus.done   = done_reg;
   assign bus.z_high = zh_reg;
   assign bus.z_low  = zl_reg;

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Multi-cycle signed multiply/divide engine that produces the 64-bit Z register pair (z_high, z_low).
- The bus mux reads this pair through its Zhigh/Zlow sources.
- Operand A comes from the Y register and operand B from the bus. A start pulse from control launches the operation; done tells control when z_high/z_low may be gated onto the bus.
- Replaces the combinational MUL/DIV path so the datapath clock is not limited by a 32x32 array.

Parameters:
- WIDTH, 32, operand width; z_high/z_low are each WIDTH bits; only 32 is verified.
- DIV0_QUOT, 32'hFFFF_FFFF, quotient written on divide-by-zero.

Ports:
- clock  input  1  rising-edge clock.
- clear_n  input  1  asynchronous active-low reset.
- start  input  1  launch request, sampled only in IDLE.
- op  input  1  0 = signed multiply, 1 = signed divide.
- a  input  WIDTH  multiplicand / dividend (from Y).
- b  input  WIDTH  multiplier / divisor (from bus).
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle pulse; Z holds the new result.
- z_high  output  WIDTH  multiply: product[63:32]; divide: remainder.
- z_low  output  WIDTH  multiply: product[31:0]; divide: quotient.

Behaviour:
- Reset (clear_n low, any time, including mid-operation):
  - state = IDLE, busy = 0, done = 0, z_high = z_low = 0, counter = 0.
  - The in-flight operation is discarded; no partial result is written.
- States: IDLE -> RUN -> FIX -> IDLE. Encoding lives in the package.
- IDLE:
  - On an edge with start = 1, latch op, sign(a), sign(b), |a| and |b| as WIDTH-bit unsigned values; clear the accumulator and set counter = 0.
  - If op = 1 and b = 0, go directly to FIX with flag div0. Otherwise go to RUN.
  - busy goes high the cycle after the start edge.
- RUN:
  - Exactly WIDTH iterations, one per clock; counter increments 0..WIDTH-1. Leave RUN on the edge where counter = WIDTH-1.
  - Multiply: shift-add on a 2*WIDTH-bit {acc, multiplier} register.
  - Divide: restoring division on {remainder, quotient}. Trial subtract is WIDTH+1 bits wide to catch the borrow.
- FIX: one cycle. Apply signs and write z_high/z_low on the FIX->IDLE edge.
  - Multiply: product negated (two's complement, 64-bit) if sign(a) XOR sign(b).
  - Divide: truncate toward zero. Quotient is negated if the signs differ; remainder takes the sign of the dividend.
  - div0: z_low = DIV0_QUOT and z_high = a, unmodified.
  - 0x8000_0000 / -1: z_low = 0x8000_0000, z_high = 0. This is the natural wrap; no trap.
- Latency, with the start edge as T0:
  - Normal operation: RUN covers edges T1..T32 and Z is written at T33. done = 1 and busy = 0 for the cycle after T33.
  - div0: Z is written at T1 and done is high in the cycle after T1.
- done is registered, high exactly one cycle, and never asserted together with busy.
- start while busy, or in the done cycle while state is not IDLE, is ignored with no queuing.
  - Because FIX returns to IDLE at T33, a start sampled in the done cycle is accepted. Back-to-back operations are therefore 34 cycles apart.
- op, a and b may change freely after the start edge; only the latched copies are used.
- z_high/z_low hold their last value in all states except the FIX write edge. The bus may read Z at any time.

Decomposition:
- Package muldiv_pkg:
  - State enum (IDLE, RUN, FIX).
  - OP_MUL = 1'b0 and OP_DIV = 1'b1.
  - WIDTH default and the counter width, $clog2(WIDTH).
- Sub-module sign_mag: combinational. It takes a WIDTH-bit value and returns the sign bit and the unsigned magnitude. Instantiated twice (a, b); the same negation logic is reused for the FIX fix-up.
- Everything else (FSM, counter, shift registers) lives in muldiv_unit.

Test Plan:
- Multiply: op=0, a=-3, b=5.
  - -> done at 34 cycles after start; z_high = 0xFFFF_FFFF, z_low = 0xFFFF_FFF1.
  - Check busy = 1 for cycles 1..33.
- Divide: op=1, a=-7, b=2 -> z_low = 0xFFFF_FFFD, z_high = 0xFFFF_FFFF. Then a=7, b=-2 -> z_low = 0xFFFF_FFFD, z_high = 1.
- Boundary cases:
  - a=0x8000_0000, b=0xFFFF_FFFF, divide -> z_low = 0x8000_0000, z_high = 0.
  - Same operands, multiply -> z = 0x0000_0000_8000_0000.
  - a=b=0x7FFF_FFFF, multiply -> z = 0x3FFF_FFFF_0000_0001.
- Divide-by-zero: a=0x1234, b=0 -> done 2 cycles after start; z_low = 0xFFFF_FFFF, z_high = 0x1234.
- Start handling:
  - Second start pulsed at cycle 10 of a running multiply is ignored; the result matches the first operands.
  - A start issued in the done cycle is accepted, with its done 34 cycles later.
- Reset: clear_n low at cycle 15 of a divide -> busy, done and Z read 0 immediately (asynchronously). After release, the unit is IDLE and a fresh 6*7 yields z_low = 42, z_high = 0.
